// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: decodes ctrl/value command pairs from the UART receiver into
// the video-splicing configuration registers, and queues reply bytes that are
// released to the UART transmitter no closer together than GAP_CYCLES.
module uart_cmd_ctrl #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int GAP_CYCLES = CLK_FREQ / BAUD * 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] ctrl_cmd,
  input  logic [3:0] value_cmd,
  input  logic       cmd_flag,
  output logic [1:0] layout_mode,
  output logic [1:0] main_ch,
  output logic [3:0] brightness,
  output logic [3:0] freeze_mask,
  output logic       cfg_update,
  output logic [7:0] tx_data,
  output logic       tx_flag,
  output logic       resp_ovf
);

  // Command codes and fixed reply bytes.
  localparam logic [3:0] CMD_LAYOUT     = 4'h1;
  localparam logic [3:0] CMD_MAIN_CH    = 4'h2;
  localparam logic [3:0] CMD_BRIGHT     = 4'h3;
  localparam logic [3:0] CMD_FREEZE     = 4'h4;
  localparam logic [3:0] CMD_QUERY      = 4'hE;
  localparam logic [3:0] CMD_SOFT_RST   = 4'hF;
  localparam logic [3:0] SOFT_RST_KEY   = 4'hA;
  localparam logic [7:0] REPLY_ERR      = 8'hEE;
  localparam logic [7:0] REPLY_SOFT_RST = 8'hFA;
  localparam logic [3:0] BRIGHT_DEFAULT = 4'd8;

  // Gap counter holds GAP_CYCLES-1 at most.
  localparam int CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic {
    ST_IDLE,
    ST_GAP
  } tx_state_e;

  // Configuration registers and status flags.
  logic [1:0] layout_q, layout_d;
  logic [1:0] main_ch_q, main_ch_d;
  logic [3:0] bright_q, bright_d;
  logic [3:0] freeze_q, freeze_d;
  logic       cfg_update_q, cfg_update_d;
  logic       resp_ovf_q, resp_ovf_d;
  logic       ovf_clr;
  logic [7:0] reply_byte;

  // Reply FIFO: 4 x 8 bits.
  logic [7:0] fifo_mem [4];
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0] count_q, count_d;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push_ok;
  logic       drop;
  logic       pop;

  // TX pacer.
  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_flag_q, tx_flag_d;

  assign fifo_full  = (count_q == 3'd4);
  assign fifo_empty = (count_q == 3'd0);
  // A full queue still accepts when the pacer frees a slot in the same cycle.
  assign push_ok    = cmd_flag && (!fifo_full || pop);
  assign drop       = cmd_flag && !push_ok;

  // Command decode: next register values, update pulse and the reply byte.
  // NOTE: every output of a combinational block gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    layout_d     = layout_q;
    main_ch_d    = main_ch_q;
    bright_d     = bright_q;
    freeze_d     = freeze_q;
    cfg_update_d = 1'b0;
    ovf_clr      = 1'b0;
    reply_byte   = REPLY_ERR;
    if (cmd_flag) begin
      case (ctrl_cmd)
        CMD_LAYOUT: begin
          if (value_cmd[3:2] == 2'b00) begin
            layout_d     = value_cmd[1:0];
            cfg_update_d = (value_cmd[1:0] != layout_q);
            reply_byte   = {CMD_LAYOUT, value_cmd};
          end
        end
        CMD_MAIN_CH: begin
          if (value_cmd[3:2] == 2'b00) begin
            main_ch_d    = value_cmd[1:0];
            cfg_update_d = (value_cmd[1:0] != main_ch_q);
            reply_byte   = {CMD_MAIN_CH, value_cmd};
          end
        end
        CMD_BRIGHT: begin
          bright_d     = value_cmd;
          cfg_update_d = (value_cmd != bright_q);
          reply_byte   = {CMD_BRIGHT, value_cmd};
        end
        CMD_FREEZE: begin
          freeze_d     = value_cmd;
          cfg_update_d = (value_cmd != freeze_q);
          reply_byte   = {CMD_FREEZE, value_cmd};
        end
        CMD_QUERY: begin
          case (value_cmd)
            4'd1:    reply_byte = {value_cmd, 2'b00, layout_q};
            4'd2:    reply_byte = {value_cmd, 2'b00, main_ch_q};
            4'd3:    reply_byte = {value_cmd, bright_q};
            4'd4:    reply_byte = {value_cmd, freeze_q};
            default: reply_byte = REPLY_ERR;
          endcase
        end
        CMD_SOFT_RST: begin
          if (value_cmd == SOFT_RST_KEY) begin
            layout_d     = 2'd0;
            main_ch_d    = 2'd0;
            bright_d     = BRIGHT_DEFAULT;
            freeze_d     = 4'd0;
            cfg_update_d = 1'b1;
            ovf_clr      = 1'b1;
            reply_byte   = REPLY_SOFT_RST;
          end
        end
        default: reply_byte = REPLY_ERR;
      endcase
    end
  end

  // Overflow flag: a dropped reply sets it even if the same command clears it.
  always_comb begin
    resp_ovf_d = resp_ovf_q;
    if (ovf_clr) begin
      resp_ovf_d = 1'b0;
    end
    if (drop) begin
      resp_ovf_d = 1'b1;
    end
  end

  // FIFO pointer and occupancy bookkeeping.
  always_comb begin
    wr_ptr_d = wr_ptr_q + {1'b0, push_ok};
    rd_ptr_d = rd_ptr_q + {1'b0, pop};
    count_d  = count_q + {2'b00, push_ok} - {2'b00, pop};
  end

  // Pacer next state: pop one byte from IDLE, then hold off in GAP so
  // successive strobes are exactly GAP_CYCLES apart when backlogged.
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    tx_data_d = tx_data_q;
    tx_flag_d = 1'b0;
    pop       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          tx_data_d = fifo_mem[rd_ptr_q];
          tx_flag_d = 1'b1;
          gap_cnt_d = GAP_LOAD;
          state_d   = ST_GAP;
        end
      end
      ST_GAP: begin
        gap_cnt_d = (gap_cnt_q == '0) ? '0 : gap_cnt_q - CNT_W'(1);
        // Leaving as the count reaches 0 lets IDLE reuse that cycle for the
        // next pop instead of adding a cycle to the spacing.
        if (gap_cnt_q <= CNT_W'(1)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset wins over a coincident command.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      layout_q     <= 2'd0;
      main_ch_q    <= 2'd0;
      bright_q     <= BRIGHT_DEFAULT;
      freeze_q     <= 4'd0;
      cfg_update_q <= 1'b0;
      resp_ovf_q   <= 1'b0;
      wr_ptr_q     <= 2'd0;
      rd_ptr_q     <= 2'd0;
      count_q      <= 3'd0;
      state_q      <= ST_IDLE;
      gap_cnt_q    <= '0;
      tx_data_q    <= 8'h00;
      tx_flag_q    <= 1'b0;
    end else begin
      layout_q     <= layout_d;
      main_ch_q    <= main_ch_d;
      bright_q     <= bright_d;
      freeze_q     <= freeze_d;
      cfg_update_q <= cfg_update_d;
      resp_ovf_q   <= resp_ovf_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      gap_cnt_q    <= gap_cnt_d;
      tx_data_q    <= tx_data_d;
      tx_flag_q    <= tx_flag_d;
    end
  end

  // FIFO storage, written on an accepted push.
  // NOTE: the storage array is not reset; the pointers and count define which
  // entries are valid, so stale contents are never read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_q] <= reply_byte;
    end
  end

  assign layout_mode = layout_q;
  assign main_ch     = main_ch_q;
  assign brightness  = bright_q;
  assign freeze_mask = freeze_q;
  assign cfg_update  = cfg_update_q;
  assign tx_data     = tx_data_q;
  assign tx_flag     = tx_flag_q;
  assign resp_ovf    = resp_ovf_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: directed and random commands against a table-driven
// model of the register bank and the ordered reply stream.
module tb_uart_cmd_ctrl;

  localparam int GAP = 8;

  logic       clk;
  logic       rst;
  logic [3:0] ctrl_cmd;
  logic [3:0] value_cmd;
  logic       cmd_flag;
  logic [1:0] layout_mode;
  logic [1:0] main_ch;
  logic [3:0] brightness;
  logic [3:0] freeze_mask;
  logic       cfg_update;
  logic [7:0] tx_data;
  logic       tx_flag;
  logic       resp_ovf;

  uart_cmd_ctrl #(
    .CLK_FREQ  (50_000_000),
    .BAUD      (115200),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ctrl_cmd   (ctrl_cmd),
    .value_cmd  (value_cmd),
    .cmd_flag   (cmd_flag),
    .layout_mode(layout_mode),
    .main_ch    (main_ch),
    .brightness (brightness),
    .freeze_mask(freeze_mask),
    .cfg_update (cfg_update),
    .tx_data    (tx_data),
    .tx_flag    (tx_flag),
    .resp_ovf   (resp_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: register index 1..4 = layout, main_ch, brightness, freeze.
  int cfg     [1:4];
  int cfg_def [1:4] = '{0, 0, 8, 0};
  int lim     [1:4] = '{3, 3, 15, 15};
  bit model_ovf;

  logic [7:0] exp_q  [$];
  logic [7:0] tx_dat [$];
  int         tx_cyc [$];
  int         chk_idx = 0;

  logic [3:0] cmd_tab [8] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hE, 4'hF, 4'h0, 4'hC};

  always @(posedge clk) cyc <= cyc + 1;

  // Record every transmitter strobe, sampled mid-cycle.
  always @(negedge clk) begin
    if (tx_flag === 1'b1) begin
      tx_dat.push_back(tx_data);
      tx_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one command to the model; returns its reply and whether a
  // configuration register changed.
  task automatic model_apply(input logic [3:0] c, input logic [3:0] v,
                             output logic [7:0] rep, output bit upd);
    rep = 8'hEE;
    upd = 1'b0;
    if (c >= 4'd1 && c <= 4'd4) begin
      if (int'(v) <= lim[c]) begin
        upd    = (cfg[c] != int'(v));
        cfg[c] = int'(v);
        rep    = {c, v};
      end
    end else if (c == 4'hE) begin
      if (v >= 4'd1 && v <= 4'd4) rep = {v, 4'(cfg[v])};
    end else if (c == 4'hF && v == 4'hA) begin
      cfg       = cfg_def;
      model_ovf = 1'b0;
      upd       = 1'b1;
      rep       = 8'hFA;
    end
  endtask

  task automatic issue(input logic [3:0] c, input logic [3:0] v, output bit upd);
    logic [7:0] rep;
    ctrl_cmd  = c;
    value_cmd = v;
    cmd_flag  = 1'b1;
    model_apply(c, v, rep, upd);
    exp_q.push_back(rep);
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_layout"}, 32'(layout_mode), cfg[1]);
    check({tag, "_main"},   32'(main_ch),     cfg[2]);
    check({tag, "_bright"}, 32'(brightness),  cfg[3]);
    check({tag, "_freeze"}, 32'(freeze_mask), cfg[4]);
    check({tag, "_ovf"},    32'(resp_ovf),    32'(model_ovf));
  endtask

  // One command in cycle T; returns at T+1 after checking its effect.
  task automatic send(input logic [3:0] c, input logic [3:0] v, input string tag);
    bit upd;
    issue(c, v, upd);
    tick();
    cmd_flag = 1'b0;
    check({tag, "_upd"}, 32'(cfg_update), 32'(upd));
    check_regs(tag);
  endtask

  // Wait (bounded) for all expected replies, then compare content and spacing.
  task automatic drain(input string tag, input bit exact_gap);
    int n;
    n = 0;
    while (tx_dat.size() < exp_q.size() && n < 400) begin
      tick();
      n++;
    end
    repeat (GAP + 4) tick();
    check({tag, "_count"}, tx_dat.size(), exp_q.size());
    for (int i = chk_idx; i < exp_q.size() && i < tx_dat.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), 32'(tx_dat[i]), 32'(exp_q[i]));
      if (i > 0) begin
        if (exact_gap && i > chk_idx)
          check($sformatf("%s_gap%0d", tag, i), tx_cyc[i] - tx_cyc[i-1], GAP);
        else
          check($sformatf("%s_mingap%0d", tag, i), 32'(tx_cyc[i] - tx_cyc[i-1] >= GAP), 1);
      end
    end
    chk_idx = exp_q.size();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit         upd;
    logic [3:0] c;
    logic [3:0] v;

    rst       = 1'b1;
    cmd_flag  = 1'b0;
    ctrl_cmd  = 4'h0;
    value_cmd = 4'h0;
    cfg       = cfg_def;
    model_ovf = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset values.
    check_regs("rst0");
    check("rst0_upd",   32'(cfg_update), 0);
    check("rst0_txd",   32'(tx_data),    0);
    check("rst0_txf",   32'(tx_flag),    0);

    // Layout 2: update at T+1, reply strobe at T+2.
    send(4'h1, 4'h2, "lay2");
    tick();
    check("lay2_txf_t2", 32'(tx_flag), 1);
    check("lay2_txd_t2", 32'(tx_data), 32'h12);
    drain("lay2", 1'b0);

    // Out-of-range value and unknown command.
    send(4'h1, 4'h7, "lay7");
    send(4'h9, 4'h0, "unk9");
    drain("err", 1'b0);

    // Brightness write, then query it back.
    send(4'h3, 4'h5, "br5");
    send(4'hE, 4'h3, "qbr");
    drain("query", 1'b0);

    // Six back-to-back commands; the sixth finds the queue full.
    issue(4'h1, 4'h1, upd); tick();
    issue(4'h2, 4'h1, upd); tick();
    issue(4'h3, 4'h3, upd); tick();
    issue(4'h4, 4'hF, upd); tick();
    issue(4'h1, 4'h0, upd); tick();
    issue(4'h2, 4'h2, upd); tick();
    cmd_flag = 1'b0;
    void'(exp_q.pop_back());
    model_ovf = 1'b1;
    check_regs("burst");
    drain("burst", 1'b1);

    // Soft reset after modifying registers, then a bad key.
    send(4'h1, 4'h3, "pre1");
    send(4'h4, 4'h5, "pre2");
    send(4'hF, 4'hA, "srst");
    send(4'hF, 4'h5, "srst_bad");
    drain("srst", 1'b0);

    // Reset while in GAP with two replies queued; a command during reset
    // is ignored.
    issue(4'h3, 4'h1, upd); tick();
    issue(4'h4, 4'h2, upd); tick();
    issue(4'h2, 4'h3, upd); tick();
    ctrl_cmd  = 4'h1;
    value_cmd = 4'h3;
    rst       = 1'b1;
    tick();
    rst       = 1'b0;
    cmd_flag  = 1'b0;
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    cfg       = cfg_def;
    model_ovf = 1'b0;
    check_regs("hrst");
    check("hrst_upd", 32'(cfg_update), 0);
    check("hrst_txd", 32'(tx_data),    0);
    check("hrst_txf", 32'(tx_flag),    0);
    drain("hrst", 1'b0);
    send(4'h2, 4'h1, "post");
    tick();
    check("post_txf_t2", 32'(tx_flag), 1);
    check("post_txd_t2", 32'(tx_data), 32'h21);
    drain("post", 1'b0);

    // Random commands, spaced so no reply is dropped.
    for (int k = 0; k < 24; k++) begin
      c = cmd_tab[$urandom_range(0, 7)];
      v = 4'($urandom);
      if (c == 4'hF && $urandom_range(0, 1) == 1) v = 4'hA;
      send(c, v, $sformatf("rnd%0d", k));
      repeat (GAP + 2) tick();
    end
    drain("rnd", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

Command decoder and configuration register bank sitting directly downstream of the UART command receiver. It consumes the 4-bit control/value pair and its one-cycle flag, and updates the video-splicing configuration registers that drive the layout and channel logic. It also produces paced acknowledge/reply bytes for the UART transmitter's `command_in`/`command_in_flag` inputs.

## Interface
- `CLK_FREQ`, 50_000_000: clock frequency in Hz.
- `BAUD`, 115200: UART baud rate.
- `GAP_CYCLES`, CLK_FREQ/BAUD*11: minimum number of cycles between `tx_flag` pulses.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `ctrl_cmd` in 4: control field, valid when `cmd_flag`=1.
- `value_cmd` in 4: value field, valid when `cmd_flag`=1.
- `cmd_flag` in 1: one-cycle command strobe.
- `layout_mode` out 2: 0 = quad, 1 = single, 2 = dual-H, 3 = dual-V.
- `main_ch` out 2: selected primary channel.
- `brightness` out 4: brightness offset.
- `freeze_mask` out 4: per-channel freeze, bit n = channel n.
- `cfg_update` out 1: one-cycle pulse when any config register changes.
- `tx_data` out 8: reply byte to the UART transmitter.
- `tx_flag` out 1: one-cycle strobe for `tx_data`.
- `resp_ovf` out 1: sticky flag, set when a reply is dropped.

## Operation
- Command decode on `cmd_flag`:
  - 0x1, layout: valid value 0–3. Sets `layout_mode`. Reply {0x1,value}.
  - 0x2, main channel: valid value 0–3. Sets `main_ch`. Reply {0x2,value}.
  - 0x3, brightness: any value is valid. Sets `brightness`. Reply {0x3,value}.
  - 0x4, freeze: any value is valid. Sets `freeze_mask`. Reply {0x4,value}.
  - 0xE, query: value 1–4 selects a register (1 = layout, 2 = main_ch, 3 = brightness, 4 = freeze). Reply {value[3:0], register zero-extended to 4 bits}. No register change.
  - 0xF, soft reset: value must be 0xA. All config registers return to defaults, `resp_ovf` clears, reply 0xFA.
- Errors (out-of-range value, unknown ctrl, or 0x0): no register change, no `cfg_update`, reply 0xEE.
- `cfg_update` pulses only when the written value differs from the current register value. A soft reset pulses `cfg_update` unconditionally.
- Response FIFO: 4 entries × 8 bits, with pointers and a count.
  - Push occurs the cycle after decode.
  - Push is accepted if not full, or if full and a pop happens in the same cycle.
  - Otherwise the reply is dropped and `resp_ovf` is set. The register update still takes effect.
- TX pacer FSM:
  - IDLE: if FIFO non-empty, pop, drive `tx_data`, pulse `tx_flag`, load gap counter with GAP_CYCLES-1, go to GAP.
  - GAP: decrement the counter. At 0, go to IDLE.
- Reset values: `layout_mode`=0, `main_ch`=0, `brightness`=8, `freeze_mask`=0, `cfg_update`=0, `tx_data`=0x00, `tx_flag`=0, `resp_ovf`=0. FIFO is empty, FSM is in IDLE, counter is 0.

## Timing
- `cmd_flag` at cycle T:
  - Register outputs update and `cfg_update` is high at T+1.
  - Reply is pushed at T+1.
  - With an empty FIFO and FSM in IDLE, `tx_flag` is high at T+2.
- `tx_flag` is high for exactly one cycle. `tx_data` holds its value until the next pop.
- Consecutive `tx_flag` rising edges are ≥ GAP_CYCLES apart.
- Back-to-back `cmd_flag` in every cycle is supported. Each command decodes independently. Replies queue, and only a 5th outstanding reply can be dropped.
- `rst` during GAP or with a non-empty FIFO: at the next edge all state returns to reset values and the queue is discarded. A byte already handed to the transmitter is not recalled.
- `rst` and `cmd_flag` asserted together: reset wins and the command is ignored.

## Test plan
- After reset, send 0x12 (layout 2): `layout_mode`=2 and `cfg_update` pulse at T+1; `tx_flag` at T+2 with `tx_data`=0x12.
- Send 0x17 (layout 7) and 0x90: both leave registers unchanged with no `cfg_update`. Replies are 0xEE then 0xEE, ≥GAP_CYCLES apart.
- Send 0x35, then 0xE3: `brightness`=5. Replies are 0x35, then 0x35 from the query.
- Send 6 commands on consecutive cycles (0x11, 0x21, 0x33, 0x4F, 0x10, 0x22):
  - Final registers: `layout_mode`=0, `main_ch`=2, `brightness`=3, `freeze_mask`=0xF.
  - First 5 replies are emitted, 6th dropped: `resp_ovf`=1.
  - `tx_flag` spacing equals GAP_CYCLES exactly.
- Send 0xFA after modifying registers: all registers return to defaults (`brightness`=8), `cfg_update` pulses, `resp_ovf` clears, reply 0xFA. Send 0xF5: reply 0xEE and no change.
- Assert `rst` for 1 cycle while in GAP with 2 replies queued: no further `tx_flag` and all outputs return to reset values. A new 0x21 afterwards gives `tx_flag` at T+2.
